// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline register chain.
package pipe_pkg;

    localparam int PIPE_MAX_DEPTH = 8;

    // A chain of depth slices holds up to 2*depth beats; counter must reach that value.
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_slice.sv
// One two-entry valid/ready slice (main + skid) with fully registered forward and backward paths.
module pipe_skid_slice
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic             rdy_q;
    logic             accept, drain;

    assign accept = in_valid && rdy_q;
    assign drain  = main_vld_q && out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (drain) begin
            // A full skid means upstream saw ready low, so no accept can coincide here.
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d = in_data;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q) begin
                main_d     = in_data;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = in_data;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= ~skid_vld_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_data  = main_q;
    assign out_valid = main_vld_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register: DEPTH skid slices in series, each breaking data, valid and ready paths.
// Optional beat counter on the occupancy port when PIPE_REG_CHAIN_OCCUPANCY_EN is defined.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
   ,output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH out of range");
    end

    // Index g is the boundary feeding slice g; index DEPTH is the chain output.
    logic [DEPTH:0][WIDTH-1:0] dat;
    logic [DEPTH:0]            vld;
    logic [DEPTH:0]            rdy;

    assign dat[0]     = in_data;
    assign vld[0]     = in_valid;
    assign in_ready   = rdy[0];
    assign out_data   = dat[DEPTH];
    assign out_valid  = vld[DEPTH];
    assign rdy[DEPTH] = out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slice
        pipe_skid_slice #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_slice (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_data   (dat[g]),
            .in_valid  (vld[g]),
            .in_ready  (rdy[g]),
            .out_data  (dat[g+1]),
            .out_valid (vld[g+1]),
            .out_ready (rdy[g+1])
        );
    end

`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
    localparam int OW = occ_width(DEPTH);

    logic [OW-1:0] occ_q, occ_d;
    logic          in_xfer, out_xfer;

    assign in_xfer  = in_valid && rdy[0];
    assign out_xfer = vld[DEPTH] && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush)
            occ_d = '0;
        else if (in_xfer && !out_xfer)
            occ_d = occ_q + OW'(1);
        else if (!in_xfer && out_xfer)
            occ_d = occ_q - OW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) occ_q <= '0;
        else      occ_q <= occ_d;
    end

    assign occupancy = occ_q;
`endif

endmodule
